// File: rtl/ram_data_sta_mirror_ctrl.sv
// Controller for the ram_data_sta_mirror status RAM: clear sweep, round-robin
// write arbitration between HW and SW requesters, and a forwarding read pipeline.
module ram_data_sta_mirror_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  clr_busy,
    input  logic                  hw_wr_req,
    input  logic [ADDR_WIDTH-1:0] hw_wr_addr,
    input  logic [DATA_WIDTH-1:0] hw_wr_data,
    output logic                  hw_wr_ack,
    input  logic                  sw_wr_req,
    input  logic [ADDR_WIDTH-1:0] sw_wr_addr,
    input  logic [DATA_WIDTH-1:0] sw_wr_data,
    output logic                  sw_wr_ack,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ack,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
    logic                  last_sw_q, last_sw_d;
    logic                  grant_hw, grant_sw;

    logic                  ram_wr_en_q, ram_wr_en_d;
    logic [ADDR_WIDTH-1:0] ram_wr_addr_q, ram_wr_addr_d;
    logic [DATA_WIDTH-1:0] ram_wr_data_q, ram_wr_data_d;

    logic [ADDR_WIDTH-1:0] ram_rd_addr_q, ram_rd_addr_d;
    logic                  rd_s1_vld_q;
    logic                  fwd_hit;

    logic [RD_LATENCY-1:0] vld_pipe_q;
    logic [RD_LATENCY-1:0] hit_pipe_q;
    logic [DATA_WIDTH-1:0] fwd_pipe_q [RD_LATENCY];

    // Clear sweep, arbitration and write-commit selection. The extra counter
    // bit flags the end of the sweep once the last address has been issued.
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        last_sw_d     = last_sw_q;
        grant_hw      = 1'b0;
        grant_sw      = 1'b0;
        ram_wr_en_d   = 1'b0;
        ram_wr_addr_d = ram_wr_addr_q;
        ram_wr_data_d = ram_wr_data_q;

        case (state_q)
            CLEAR: begin
                ram_wr_en_d   = 1'b1;
                ram_wr_addr_d = clr_cnt_q[ADDR_WIDTH-1:0];
                ram_wr_data_d = '0;
                clr_cnt_d     = clr_cnt_q + 1'b1;
                if (clr_cnt_d[ADDR_WIDTH]) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end else if (hw_wr_req && sw_wr_req) begin
                    grant_hw = last_sw_q;
                    grant_sw = !last_sw_q;
                end else begin
                    grant_hw = hw_wr_req;
                    grant_sw = sw_wr_req;
                end

                if (grant_hw) begin
                    ram_wr_en_d   = 1'b1;
                    ram_wr_addr_d = hw_wr_addr;
                    ram_wr_data_d = hw_wr_data;
                    last_sw_d     = 1'b0;
                end else if (grant_sw) begin
                    ram_wr_en_d   = 1'b1;
                    ram_wr_addr_d = sw_wr_addr;
                    ram_wr_data_d = sw_wr_data;
                    last_sw_d     = 1'b1;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    assign rd_ack        = rd_req && (state_q == RUN);
    assign ram_rd_addr_d = rd_ack ? rd_addr : ram_rd_addr_q;

    // A write committing to the address the RAM is reading this cycle would
    // return stale data, so capture the write data alongside the read.
    assign fwd_hit = rd_s1_vld_q && ram_wr_en_q && (ram_wr_addr_q == ram_rd_addr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= CLEAR;
            clr_cnt_q     <= '0;
            last_sw_q     <= 1'b1;
            ram_wr_en_q   <= 1'b0;
            ram_wr_addr_q <= '0;
            ram_wr_data_q <= '0;
            ram_rd_addr_q <= '0;
            rd_s1_vld_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            last_sw_q     <= last_sw_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_wr_addr_q <= ram_wr_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            ram_rd_addr_q <= ram_rd_addr_d;
            rd_s1_vld_q   <= rd_ack;
        end
    end

    // Delay line matching the RAM read latency for valid and forwarded data.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            hit_pipe_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                fwd_pipe_q[i] <= '0;
            end
        end else begin
            vld_pipe_q[0] <= rd_s1_vld_q;
            hit_pipe_q[0] <= fwd_hit;
            fwd_pipe_q[0] <= ram_wr_data_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                hit_pipe_q[i] <= hit_pipe_q[i-1];
                fwd_pipe_q[i] <= fwd_pipe_q[i-1];
            end
        end
    end

    assign rd_vld  = vld_pipe_q[RD_LATENCY-1];
    assign rd_data = !rd_vld                     ? '0 :
                     hit_pipe_q[RD_LATENCY-1]    ? fwd_pipe_q[RD_LATENCY-1] :
                                                   ram_rd_data;

    assign clr_busy    = (state_q == CLEAR);
    assign hw_wr_ack   = grant_hw;
    assign sw_wr_ack   = grant_sw;
    assign ram_wr_en   = ram_wr_en_q;
    assign ram_wr_addr = ram_wr_addr_q;
    assign ram_wr_data = ram_wr_data_q;
    assign ram_rd_addr = ram_rd_addr_q;

endmodule

// File: doc/ram_data_sta_mirror_ctrl.md
# ram_data_sta_mirror_ctrl

Single-clock controller for the `ram_data_sta_mirror` status RAM (simple dual-port, 2^ADDR_WIDTH x DATA_WIDTH).
- Clears the whole RAM after reset and on request.
- Arbitrates two write requesters, hardware status updates and software writes, round-robin onto the single RAM write port.
- Drives the RAM read port with a fixed-latency read pipeline, forwarding same-cycle write data.
- Sits between the link status logic / register bank and the RAM instance; both RAM clocks connect to `clk`.

## Interface
- ADDR_WIDTH, 4, RAM address width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 64, RAM data width.
- RD_LATENCY, 1, RAM read latency in cycles: 1 for OUT_REG=0, 2 for OUT_REG=1.

Ports:
- clk  in  1  single clock, also drives RAM wr_clk and rd_clk.
- rst  in  1  reset, synchronous, active-high.
- clr_req  in  1  start a full RAM clear sweep.
- clr_busy  out  1  high while the clear sweep runs.
- hw_wr_req  in  1  hardware write request, held until acked.
- hw_wr_addr  in  ADDR_WIDTH  hardware write address.
- hw_wr_data  in  DATA_WIDTH  hardware write data.
- hw_wr_ack  out  1  one-cycle grant pulse.
- sw_wr_req, sw_wr_addr, sw_wr_data, sw_wr_ack  same as the hw_* ports, for the software requester.
- rd_req  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_ack  out  1  read accepted; combinational: `rd_req && state==RUN`.
- rd_vld  out  1  read data valid pulse.
- rd_data  out  DATA_WIDTH  read data.
- ram_wr_en  out  1  to RAM wr_en.
- ram_wr_addr  out  ADDR_WIDTH  to RAM wr_addr.
- ram_wr_data  out  DATA_WIDTH  to RAM wr_data.
- ram_rd_addr  out  ADDR_WIDTH  to RAM rd_addr.
- ram_rd_data  in  DATA_WIDTH  from RAM rd_data.

## Operation
- FSM states: CLEAR and RUN.
  - rst forces CLEAR with clear address 0, regardless of any operation in flight.
  - CLEAR writes zero to addresses 0 .. 2^ADDR_WIDTH-1, one per cycle, then enters RUN.
  - In RUN, clr_req=1 moves to CLEAR at the next edge with clear address 0.
  - clr_req is ignored while already in CLEAR.
- clr_busy = (state == CLEAR).
- Write arbitration, RUN only:
  - Grant is combinational in the cycle requests are seen; the granted requester's ack pulses for 1 cycle.
  - If both request, grant the requester not granted last. The `last` register resets to SW, so HW wins the first tie.
  - A single requester is granted immediately. A requester holds req, addr and data stable until its ack.
  - No grants are issued in CLEAR, or in a RUN cycle where clr_req=1 (clear has priority; the pending request waits).
- Write commit: the granted addr/data are registered into ram_wr_* with ram_wr_en=1 in the cycle after the grant. CLEAR drives ram_wr_* the same way, with data 0.
- Read path:
  - A read accepted at cycle t registers rd_addr into ram_rd_addr at t+1.
  - rd_vld and rd_data appear at t+1+RD_LATENCY. The pipeline accepts one read per cycle.
  - Reads are not accepted in CLEAR (rd_ack=0). Reads already in flight when CLEAR starts still complete.
- Forwarding: if ram_wr_en=1 and ram_wr_addr == ram_rd_addr in the same cycle, rd_data returns that cycle's ram_wr_data instead of ram_rd_data. This covers the RAM's old-data hazard.

## Timing
- Reset values: clr_busy=1, hw_wr_ack=0, sw_wr_ack=0, rd_vld=0, rd_data=0, ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, ram_rd_addr=0.
- The first clear write (address 0) happens in the first cycle after rst deasserts.
- A clear sweep takes exactly 2^ADDR_WIDTH cycles. clr_busy falls on the edge after the write to the last address; the first grant is possible in that cycle.
- Write latency: req→ack 0 cycles when uncontended; ack→RAM write 1 cycle.
- Worst-case wait under continuous contention is 1 cycle.
- Read latency: rd_req→rd_vld = 1+RD_LATENCY cycles.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. The clear counter is ADDR_WIDTH+1 bits wide so it terminates correctly.

## Test plan
- Reset release:
  - Expect clr_busy high for 16 cycles, with ram_wr_en=1 and data 0 at addresses 0..15.
  - Then read all 16 addresses; every rd_data must be 0, each returned 2 cycles after rd_req (RD_LATENCY=1).
- Single requester: hw writes addr 3 = 0xA5A5_A5A5_A5A5_A5A5.
  - hw_wr_ack in the same cycle; ram_wr_en one cycle later.
  - Reading addr 3 returns 0xA5A5…A5.
- Contention: hw and sw both hold requests for addrs 5 and 6.
  - Grants go HW, SW, HW, SW, …, with no cycle lost.
  - Final RAM contents match the last granted data at each address.
- Forwarding: issue a sw write to addr 9 = all-ones, timed so ram_rd_addr=9 in the same cycle as the write commit.
  - rd_data must equal all-ones, not the old value 0.
- Clear mid-run:
  - Write addrs 0..15 with nonzero data, then assert clr_req while hw_wr_req is pending.
  - No ack is issued during the clear. The hw request is granted the cycle clr_busy falls.
  - All other addresses read 0 afterwards.
- rst mid-clear:
  - Assert rst at clear address 7. The sweep restarts at 0 and takes 16 full cycles.
  - rd_vld stays 0 throughout.
